// File: rtl/rs_age_select_if.sv
// Allocation, result-broadcast, issue and flush signals of the rs_age_select issue queue.
// master drives allocation/wakeup/issue-accept; slave is the issue queue itself.
interface rs_age_select_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned PRF_W  = 6,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned NUM_WB = 2
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [OP_W-1:0]         in_op;
  logic [PRF_W-1:0]        in_tag_prf;
  logic [ROB_W-1:0]        in_tag_rob;
  logic                    in_rdy_a;
  logic [PRF_W-1:0]        in_tag_a;
  logic                    in_rdy_b;
  logic [PRF_W-1:0]        in_tag_b;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*PRF_W-1:0] wb_tag;
  logic                    iss_ready;
  logic                    iss_valid;
  logic [OP_W-1:0]         iss_op;
  logic [PRF_W-1:0]        iss_tag_prf;
  logic [ROB_W-1:0]        iss_tag_rob;
  logic [PRF_W-1:0]        iss_tag_a;
  logic [PRF_W-1:0]        iss_tag_b;
  logic [CNT_W-1:0]        count;

  modport master (
    output flush, in_valid, in_op, in_tag_prf, in_tag_rob, in_rdy_a, in_tag_a,
           in_rdy_b, in_tag_b, wb_valid, wb_tag, iss_ready,
    input  in_ready, iss_valid, iss_op, iss_tag_prf, iss_tag_rob, iss_tag_a, iss_tag_b,
           count
  );

  modport slave (
    input  flush, in_valid, in_op, in_tag_prf, in_tag_rob, in_rdy_a, in_tag_a,
           in_rdy_b, in_tag_b, wb_valid, wb_tag, iss_ready,
    output in_ready, iss_valid, iss_op, iss_tag_prf, iss_tag_rob, iss_tag_a, iss_tag_b,
           count
  );
endinterface

// File: rtl/rs_age_select.sv
// Issue queue for one execution cluster: operand wakeup from NUM_WB broadcasts, registered issue
// slot. RS_AGE_ORDER_EN selects the oldest ready entry via an age matrix, else the lowest index.
module rs_age_select #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned PRF_W  = 6,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned NUM_WB = 2
) (
  input logic            clk,
  input logic            rst,
  rs_age_select_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy_a_q, rdy_a_d;
  logic [DEPTH-1:0] rdy_b_q, rdy_b_d;
  logic [OP_W-1:0]  op_q      [DEPTH];
  logic [PRF_W-1:0] tag_prf_q [DEPTH];
  logic [ROB_W-1:0] tag_rob_q [DEPTH];
  logic [PRF_W-1:0] tag_a_q   [DEPTH];
  logic [PRF_W-1:0] tag_b_q   [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic             iss_valid_q;
  logic [OP_W-1:0]  iss_op_q;
  logic [PRF_W-1:0] iss_tag_prf_q;
  logic [ROB_W-1:0] iss_tag_rob_q;
  logic [PRF_W-1:0] iss_tag_a_q;
  logic [PRF_W-1:0] iss_tag_b_q;

  logic             in_ready;
  logic             alloc;
  logic             do_sel;
  logic             sel_any;
  logic             sel_hit;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] pick;

  function automatic logic wb_match(input logic [PRF_W-1:0]        tag,
                                    input logic [NUM_WB-1:0]       v,
                                    input logic [NUM_WB*PRF_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (v[k] && (t[k*PRF_W +: PRF_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // in_ready depends on registered count only, so a slot freed this cycle waits one cycle.
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign alloc    = bus.in_valid & in_ready & ~bus.flush;
  assign do_sel   = ~iss_valid_q | bus.iss_ready;
  assign cand     = valid_q & rdy_a_q & rdy_b_q;
  assign sel_hit  = do_sel & sel_any;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] = 1: entry i was allocated before entry j.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pick[i] = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && cand[j] && !age_q[i][j]) pick[i] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
    if (alloc) begin
      age_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_q[j] && (IDX_W'(j) != free_idx)) age_d[j][free_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end
`else
  assign pick = cand;
`endif

  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick[i] && !sel_any) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy_a_d = rdy_a_q;
    rdy_b_d = rdy_b_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (wb_match(tag_a_q[i], bus.wb_valid, bus.wb_tag)) rdy_a_d[i] = 1'b1;
        if (wb_match(tag_b_q[i], bus.wb_valid, bus.wb_tag)) rdy_b_d[i] = 1'b1;
      end
    end
    if (sel_hit) valid_d[sel_idx] = 1'b0;
    // Selected entry is valid, allocated one is free: the two indices never collide.
    if (alloc) begin
      valid_d[free_idx] = 1'b1;
      rdy_a_d[free_idx] = bus.in_rdy_a | wb_match(bus.in_tag_a, bus.wb_valid, bus.wb_tag);
      rdy_b_d[free_idx] = bus.in_rdy_b | wb_match(bus.in_tag_b, bus.wb_valid, bus.wb_tag);
    end
  end

  assign count_d = count_q + CNT_W'(alloc) - CNT_W'(sel_hit);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q <= '0;
      rdy_a_q <= '0;
      rdy_b_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_a_q <= rdy_a_d;
      rdy_b_q <= rdy_b_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      op_q[free_idx]      <= bus.in_op;
      tag_prf_q[free_idx] <= bus.in_tag_prf;
      tag_rob_q[free_idx] <= bus.in_tag_rob;
      tag_a_q[free_idx]   <= bus.in_tag_a;
      tag_b_q[free_idx]   <= bus.in_tag_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      iss_valid_q   <= 1'b0;
      iss_op_q      <= '0;
      iss_tag_prf_q <= '0;
      iss_tag_rob_q <= '0;
      iss_tag_a_q   <= '0;
      iss_tag_b_q   <= '0;
    end else if (do_sel) begin
      iss_valid_q <= sel_any;
      if (sel_any) begin
        iss_op_q      <= op_q[sel_idx];
        iss_tag_prf_q <= tag_prf_q[sel_idx];
        iss_tag_rob_q <= tag_rob_q[sel_idx];
        iss_tag_a_q   <= tag_a_q[sel_idx];
        iss_tag_b_q   <= tag_b_q[sel_idx];
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.iss_valid   = iss_valid_q;
  assign bus.iss_op      = iss_op_q;
  assign bus.iss_tag_prf = iss_tag_prf_q;
  assign bus.iss_tag_rob = iss_tag_rob_q;
  assign bus.iss_tag_a   = iss_tag_a_q;
  assign bus.iss_tag_b   = iss_tag_b_q;
  assign bus.count       = count_q;

endmodule
